// File: rtl/neg_cycle_tracer.sv
// neg_cycle_tracer
//   Post-pass checker for a Bellman-Ford engine. Walks every (i,j) edge of the
//   adjacency matrix; an edge that still relaxes proves a negative-weight cycle.
//   The predecessor chain is followed NODES steps from j to land on the cycle,
//   then the cycle's vertices are streamed out (start, pred(start), ...) over a
//   valid/ready port. A visited bitmap suppresses repeat reports and at most
//   MAX_CYCLES cycles are emitted per scan.
//
//   Ports
//     clk, cycle_reset          clock, synchronous active-high reset
//     start                     begin a scan (accepted in IDLE/DONE)
//     vert_addr_a / vert_q_a    vertmat port A: source vertex {pred, weight}
//     vert_addr_b / vert_q_b    vertmat port B: dest vertex or walk vertex
//     adj_row, adj_col / adj_q  adjmat read, signed weight, 0 = no edge
//     cyc_valid/ready/vert/last/id   cycle vertex stream
//     busy, done, overflow, trace_err  scan status
module neg_cycle_tracer #(
  parameter int NODES      = 4,
  parameter int WEIGHT_W   = 32,
  parameter int PRED_W     = 2,
  parameter int MAX_CYCLES = 4,
  localparam int VERT_W    = PRED_W + WEIGHT_W,
  localparam int ID_W      = $clog2(MAX_CYCLES + 1)
) (
  input  logic                       clk,
  input  logic                       cycle_reset,
  input  logic                       start,
  output logic [PRED_W-1:0]          vert_addr_a,
  input  logic [VERT_W-1:0]          vert_q_a,
  output logic [PRED_W-1:0]          vert_addr_b,
  input  logic [VERT_W-1:0]          vert_q_b,
  output logic [PRED_W-1:0]          adj_row,
  output logic [PRED_W-1:0]          adj_col,
  input  logic signed [WEIGHT_W-1:0] adj_q,
  output logic                       cyc_valid,
  input  logic                       cyc_ready,
  output logic [PRED_W-1:0]          cyc_vert,
  output logic                       cyc_last,
  output logic [ID_W-1:0]            cyc_id,
  output logic                       busy,
  output logic                       done,
  output logic                       overflow,
  output logic                       trace_err
);

  typedef enum logic [2:0] {
    S_IDLE, S_SCAN_ADDR, S_SCAN_CHK, S_WALK, S_TRACE, S_EMIT, S_DONE
  } state_t;

  localparam logic [PRED_W-1:0] LAST_IDX = PRED_W'(NODES - 1);
  localparam logic [ID_W-1:0]   MAX_ID   = ID_W'(MAX_CYCLES);

  // Sign-extend by one bit so w_i + adj can never wrap before the compare.
  function automatic logic relaxes(input logic signed [WEIGHT_W-1:0] wi,
                                   input logic signed [WEIGHT_W-1:0] adj,
                                   input logic signed [WEIGHT_W-1:0] wj);
    logic signed [WEIGHT_W:0] sum;
    logic signed [WEIGHT_W:0] wj_x;
    sum  = {wi[WEIGHT_W-1], wi} + {adj[WEIGHT_W-1], adj};
    wj_x = {wj[WEIGHT_W-1], wj};
    return (adj != '0) && (sum < wj_x);
  endfunction

  state_t                state_q, state_d;
  logic [PRED_W-1:0]     i_q, i_d, j_q, j_d;
  logic [PRED_W-1:0]     v_q, v_d, pv_q, pv_d, cstart_q, cstart_d;
  logic [PRED_W-1:0]     step_q, step_d, ecnt_q, ecnt_d;
  logic                  ph_q, ph_d;
  logic [NODES-1:0]      visited_q, visited_d;
  logic [ID_W-1:0]       count_q, count_d;
  logic                  overflow_q, overflow_d, trace_err_q, trace_err_d;

  logic signed [WEIGHT_W-1:0] w_i, w_j;
  logic [PRED_W-1:0]     pred_b;
  logic                  relax, last_edge, emit, nat_last, force_last, last_beat, resume;
  logic                  unused_pred_a;

  assign w_i       = vert_q_a[WEIGHT_W-1:0];
  assign w_j       = vert_q_b[WEIGHT_W-1:0];
  assign pred_b    = vert_q_b[VERT_W-1:WEIGHT_W];
  // The scan only needs the source weight; its predecessor field is unused.
  assign unused_pred_a = ^vert_q_a[VERT_W-1:WEIGHT_W];
  assign relax     = relaxes(w_i, adj_q, w_j);
  assign last_edge = (i_q == LAST_IDX) && (j_q == LAST_IDX);

  // pv_q holds pred(v) fetched in TRACE, so cyc_last stays stable under stall.
  assign emit       = (state_q == S_EMIT);
  assign nat_last   = (pv_q == cstart_q);
  assign force_last = (ecnt_q == LAST_IDX) && !nat_last;
  assign last_beat  = nat_last || force_last;

  assign vert_addr_a = i_q;
  assign adj_row     = i_q;
  assign adj_col     = j_q;
  assign vert_addr_b = (state_q == S_WALK || state_q == S_TRACE || emit) ? v_q : j_q;
  assign cyc_valid   = emit;
  assign cyc_vert    = emit ? v_q : '0;
  assign cyc_last    = emit && last_beat;
  assign cyc_id      = count_q;
  assign busy        = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done        = (state_q == S_DONE);
  assign overflow    = overflow_q;
  assign trace_err   = trace_err_q;

  always_comb begin
    state_d     = state_q;
    i_d         = i_q;
    j_d         = j_q;
    v_d         = v_q;
    pv_d        = pv_q;
    cstart_d    = cstart_q;
    step_d      = step_q;
    ecnt_d      = ecnt_q;
    ph_d        = ph_q;
    visited_d   = visited_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    trace_err_d = trace_err_q;
    resume      = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d     = S_SCAN_ADDR;
          i_d         = '0;
          j_d         = '0;
          visited_d   = '0;
          count_d     = '0;
          overflow_d  = 1'b0;
          trace_err_d = 1'b0;
        end
      end
      S_SCAN_ADDR: state_d = S_SCAN_CHK;
      S_SCAN_CHK: begin
        if (relax) begin
          v_d     = j_q;
          step_d  = '0;
          ph_d    = 1'b0;
          state_d = S_WALK;
        end else begin
          resume = 1'b1;
        end
      end
      // Two cycles per predecessor hop: address v, then read pred(v).
      S_WALK: begin
        if (!ph_q) begin
          ph_d = 1'b1;
        end else begin
          ph_d = 1'b0;
          v_d  = pred_b;
          if (step_q == LAST_IDX) begin
            if (visited_q[pred_b]) begin
              resume = 1'b1;
            end else if (count_q == MAX_ID) begin
              overflow_d = 1'b1;
              resume     = 1'b1;
            end else begin
              cstart_d = pred_b;
              ecnt_d   = '0;
              state_d  = S_TRACE;
            end
          end else begin
            step_d = step_q + PRED_W'(1);
          end
        end
      end
      S_TRACE: begin
        if (!ph_q) begin
          ph_d = 1'b1;
        end else begin
          ph_d    = 1'b0;
          pv_d    = pred_b;
          state_d = S_EMIT;
        end
      end
      S_EMIT: begin
        if (cyc_ready) begin
          visited_d[v_q] = 1'b1;
          if (last_beat) begin
            count_d = count_q + ID_W'(1);
            if (force_last) trace_err_d = 1'b1;
            resume = 1'b1;
          end else begin
            v_d     = pv_q;
            ecnt_d  = ecnt_q + PRED_W'(1);
            state_d = S_TRACE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (resume) begin
      if (last_edge) begin
        state_d = S_DONE;
      end else begin
        state_d = S_SCAN_ADDR;
        if (j_q == LAST_IDX) begin
          j_d = '0;
          i_d = i_q + PRED_W'(1);
        end else begin
          j_d = j_q + PRED_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (cycle_reset) state_q <= S_IDLE;
    else             state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (cycle_reset) begin
      i_q         <= '0;
      j_q         <= '0;
      v_q         <= '0;
      pv_q        <= '0;
      cstart_q    <= '0;
      step_q      <= '0;
      ecnt_q      <= '0;
      ph_q        <= 1'b0;
      visited_q   <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      trace_err_q <= 1'b0;
    end else begin
      i_q         <= i_d;
      j_q         <= j_d;
      v_q         <= v_d;
      pv_q        <= pv_d;
      cstart_q    <= cstart_d;
      step_q      <= step_d;
      ecnt_q      <= ecnt_d;
      ph_q        <= ph_d;
      visited_q   <= visited_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      trace_err_q <= trace_err_d;
    end
  end

endmodule

// File: tb/tb_neg_cycle_tracer.sv
// Bench for neg_cycle_tracer: two instances (MAX_CYCLES=4 and MAX_CYCLES=1)
// share the graph contents, start, reset and ready; each has its own RAM reads.
module tb_neg_cycle_tracer;
  localparam int NODES = 4, WEIGHT_W = 32, PRED_W = 2;
  localparam int MAX1 = 4, MAX2 = 1;
  localparam int VERT_W = PRED_W + WEIGHT_W;
  localparam int ID1 = $clog2(MAX1 + 1), ID2 = $clog2(MAX2 + 1);

  logic clk = 1'b0;
  logic cycle_reset = 1'b1;
  logic start = 1'b0;
  logic cyc_ready = 1'b1;

  logic [VERT_W-1:0]          vmem [NODES];
  logic signed [WEIGHT_W-1:0] amem [NODES][NODES];

  logic [PRED_W-1:0] d1_aa, d1_ab, d1_row, d1_col, d1_vert;
  logic [VERT_W-1:0] d1_qa, d1_qb;
  logic signed [WEIGHT_W-1:0] d1_adj;
  logic d1_valid, d1_last, d1_busy, d1_done, d1_ovf, d1_terr;
  logic [ID1-1:0] d1_id;

  logic [PRED_W-1:0] d2_aa, d2_ab, d2_row, d2_col, d2_vert;
  logic [VERT_W-1:0] d2_qa, d2_qb;
  logic signed [WEIGHT_W-1:0] d2_adj;
  logic d2_valid, d2_last, d2_busy, d2_done, d2_ovf, d2_terr;
  logic [ID2-1:0] d2_id;

  neg_cycle_tracer #(.NODES(NODES), .WEIGHT_W(WEIGHT_W), .PRED_W(PRED_W), .MAX_CYCLES(MAX1)) dut (
    .clk(clk), .cycle_reset(cycle_reset), .start(start),
    .vert_addr_a(d1_aa), .vert_q_a(d1_qa), .vert_addr_b(d1_ab), .vert_q_b(d1_qb),
    .adj_row(d1_row), .adj_col(d1_col), .adj_q(d1_adj),
    .cyc_valid(d1_valid), .cyc_ready(cyc_ready), .cyc_vert(d1_vert), .cyc_last(d1_last),
    .cyc_id(d1_id), .busy(d1_busy), .done(d1_done), .overflow(d1_ovf), .trace_err(d1_terr));

  neg_cycle_tracer #(.NODES(NODES), .WEIGHT_W(WEIGHT_W), .PRED_W(PRED_W), .MAX_CYCLES(MAX2)) dut2 (
    .clk(clk), .cycle_reset(cycle_reset), .start(start),
    .vert_addr_a(d2_aa), .vert_q_a(d2_qa), .vert_addr_b(d2_ab), .vert_q_b(d2_qb),
    .adj_row(d2_row), .adj_col(d2_col), .adj_q(d2_adj),
    .cyc_valid(d2_valid), .cyc_ready(cyc_ready), .cyc_vert(d2_vert), .cyc_last(d2_last),
    .cyc_id(d2_id), .busy(d2_busy), .done(d2_done), .overflow(d2_ovf), .trace_err(d2_terr));

  always #5 clk = ~clk;

  // 1-cycle-latency RAM reads
  always @(posedge clk) begin
    d1_qa  <= vmem[d1_aa];
    d1_qb  <= vmem[d1_ab];
    d1_adj <= amem[d1_row][d1_col];
    d2_qa  <= vmem[d2_aa];
    d2_qb  <= vmem[d2_ab];
    d2_adj <= amem[d2_row][d2_col];
  end

  int tests_run = 0;
  int failures = 0;

  // beat = 256*id + 16*last + vert
  int beat1, beat2;
  assign beat1 = 256 * int'(d1_id) + 16 * int'(d1_last) + int'(d1_vert);
  assign beat2 = 256 * int'(d2_id) + 16 * int'(d2_last) + int'(d2_vert);

  int got1[$];
  int got2[$];
  int hold_err = 0;
  bit stall1 = 1'b0;
  int held1 = 0;

  always @(negedge clk) begin
    if (d1_valid && cyc_ready) got1.push_back(beat1);
    if (d2_valid && cyc_ready) got2.push_back(beat2);
    if (stall1 && !(d1_valid && beat1 == held1)) hold_err <= hold_err + 1;
    stall1 <= d1_valid && !cyc_ready && !cycle_reset;
    held1  <= beat1;
  end

  // ---------------- reference model ----------------
  int exp_q[$];
  bit exp_ovf, exp_terr;

  function automatic int predof(input int x);
    return int'(vmem[x][VERT_W-1:WEIGHT_W]);
  endfunction

  function automatic longint wof(input int x);
    logic signed [WEIGHT_W-1:0] w;
    w = vmem[x][WEIGHT_W-1:0];
    return longint'(w);
  endfunction

  task automatic model(input int maxc);
    bit vis[NODES];
    int cnt, v, u, k;
    bit last;
    longint a;
    exp_q.delete();
    exp_ovf = 1'b0;
    exp_terr = 1'b0;
    cnt = 0;
    foreach (vis[x]) vis[x] = 1'b0;
    for (int i = 0; i < NODES; i++) begin
      for (int j = 0; j < NODES; j++) begin
        a = longint'(amem[i][j]);
        if (a == 0 || wof(i) + a >= wof(j)) continue;
        v = j;
        for (int s = 0; s < NODES; s++) v = predof(v);
        if (vis[v]) continue;
        if (cnt == maxc) begin
          exp_ovf = 1'b1;
          continue;
        end
        u = v;
        k = 0;
        forever begin
          k++;
          last = (predof(u) == v);
          if (!last && k == NODES) begin
            last = 1'b1;
            exp_terr = 1'b1;
          end
          exp_q.push_back(256 * cnt + 16 * int'(last) + u);
          vis[u] = 1'b1;
          if (last) break;
          u = predof(u);
        end
        cnt++;
      end
    end
  endtask

  // ---------------- stimulus helpers ----------------
  function automatic logic [VERT_W-1:0] mkv(input int p, input int w);
    logic [31:0] pw, ww;
    pw = p;
    ww = w;
    return {pw[PRED_W-1:0], ww[WEIGHT_W-1:0]};
  endfunction

  task automatic clear_graph();
    for (int x = 0; x < NODES; x++) begin
      vmem[x] = mkv(x, 0);
      for (int y = 0; y < NODES; y++) amem[x][y] = '0;
    end
  endtask

  task automatic set_triangle();
    clear_graph();
    vmem[0] = mkv(2, 0);
    vmem[1] = mkv(0, 0);
    vmem[2] = mkv(1, 0);
    amem[0][1] = -1;
    amem[1][2] = -1;
    amem[2][0] = -1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Called at posedge+1; returns cycles from the start cycle until both report done.
  task automatic run_scan(input bit rand_ready, output int cyc);
    cyc_ready = 1'b1;
    pulse_start();
    cyc = 1;
    while (!(d1_done && d2_done) && cyc < 3000) begin
      if (rand_ready) cyc_ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      cyc++;
    end
    cyc_ready = 1'b1;
    tests_run++;
    if (!(d1_done && d2_done)) begin
      failures++;
      $display("FAIL scan_timeout: done=%0b/%0b after %0d cycles, required 1/1", d1_done, d2_done, cyc);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    cycle_reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    tests_run++;
    if ({d1_valid, d1_last, d1_vert, d1_id, d1_busy, d1_done, d1_ovf, d1_terr} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: valid=%0b last=%0b vert=%0d id=%0d busy=%0b done=%0b ovf=%0b terr=%0b, required all 0",
               d1_valid, d1_last, d1_vert, d1_id, d1_busy, d1_done, d1_ovf, d1_terr);
    end
    tests_run++;
    if ({d1_aa, d1_ab, d1_row, d1_col} !== '0) begin
      failures++;
      $display("FAIL reset_addr: a=%0d b=%0d row=%0d col=%0d, required 0", d1_aa, d1_ab, d1_row, d1_col);
    end
    cycle_reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if (d1_busy !== 1'b0 || d1_done !== 1'b0) begin
      failures++;
      $display("FAIL idle_hold: busy=%0b done=%0b, required 0 0", d1_busy, d1_done);
    end
  endtask

  task automatic test_no_cycle();
    int b, cyc;
    clear_graph();
    for (int x = 0; x < NODES; x++)
      for (int y = 0; y < NODES; y++) amem[x][y] = $urandom_range(0, 20);
    b = got1.size();
    run_scan(1'b0, cyc);
    tests_run++;
    if (cyc != 2 * NODES * NODES + 1) begin
      failures++;
      $display("FAIL no_cycle_latency: done after %0d cycles, required %0d", cyc, 2 * NODES * NODES + 1);
    end
    tests_run++;
    if (got1.size() != b || d1_busy !== 1'b0) begin
      failures++;
      $display("FAIL no_cycle_beats: %0d beats busy=%0b, required 0 beats busy=0", got1.size() - b, d1_busy);
    end
  endtask

  task automatic test_triangle();
    int b, cyc;
    set_triangle();
    model(MAX1);
    b = got1.size();
    run_scan(1'b0, cyc);
    tests_run++;
    if (got1.size() - b != 3) begin
      failures++;
      $display("FAIL tri_len: %0d beats, required 3", got1.size() - b);
    end else begin
      tests_run++;
      if (got1[b] !== 0 || got1[b+1] !== 2 || got1[b+2] !== 17) begin
        failures++;
        $display("FAIL tri_beats: %0d %0d %0d, required 0 2 17", got1[b], got1[b+1], got1[b+2]);
      end
    end
    tests_run++;
    if (exp_q.size() != 3 || d1_ovf !== 1'b0) begin
      failures++;
      $display("FAIL tri_model_ovf: model beats %0d ovf=%0b, required 3 0", exp_q.size(), d1_ovf);
    end
  endtask

  task automatic test_backpressure();
    int b, held, n;
    set_triangle();
    b = got1.size();
    cyc_ready = 1'b1;
    pulse_start();
    n = 0;
    while (!(got1.size() == b + 1 && d1_valid) && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    tests_run++;
    if (n >= 500) begin
      failures++;
      $display("FAIL bp_wait: second beat not seen, required within 500 cycles");
    end
    cyc_ready = 1'b0;
    held = beat1;
    tests_run++;
    if (held != 2) begin
      failures++;
      $display("FAIL bp_beat2: beat %0d, required 2", held);
    end
    repeat (5) begin
      @(posedge clk); #1;
      tests_run++;
      if (d1_valid !== 1'b1 || beat1 != held) begin
        failures++;
        $display("FAIL bp_hold: valid=%0b beat=%0d, required 1 %0d", d1_valid, beat1, held);
      end
    end
    cyc_ready = 1'b1;
    n = 0;
    while (!(d1_done && d2_done) && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    tests_run++;
    if (got1.size() - b != 3 || got1[b] !== 0 || got1[b+1] !== 2 || got1[b+2] !== 17) begin
      failures++;
      $display("FAIL bp_stream: %0d beats, required 3 beats 0 2 17", got1.size() - b);
    end
  endtask

  task automatic test_self_loop();
    int b, cyc;
    clear_graph();
    amem[3][3] = -5;
    b = got1.size();
    run_scan(1'b0, cyc);
    tests_run++;
    if (got1.size() - b != 1 || got1[b] !== 19) begin
      failures++;
      $display("FAIL self_loop: %0d beats first=%0d, required 1 beat 19",
               got1.size() - b, (got1.size() > b) ? got1[b] : -1);
    end
  endtask

  task automatic test_overflow();
    int b1, b2, cyc;
    clear_graph();
    vmem[0] = mkv(1, 0);
    vmem[1] = mkv(0, 0);
    vmem[2] = mkv(3, 0);
    vmem[3] = mkv(2, 0);
    amem[0][1] = -1;
    amem[1][0] = -1;
    amem[2][3] = -1;
    amem[3][2] = -1;
    b1 = got1.size();
    b2 = got2.size();
    run_scan(1'b0, cyc);
    tests_run++;
    if (got2.size() - b2 != 2 || got2[b2] !== 1 || got2[b2+1] !== 16 || d2_ovf !== 1'b1 || d2_done !== 1'b1) begin
      failures++;
      $display("FAIL ovf_max1: %0d beats ovf=%0b done=%0b, required 2 beats (1,16) ovf=1 done=1",
               got2.size() - b2, d2_ovf, d2_done);
    end
    tests_run++;
    if (got1.size() - b1 != 4 || got1[b1+2] !== 256 + 3 || got1[b1+3] !== 256 + 16 + 2 || d1_ovf !== 1'b0) begin
      failures++;
      $display("FAIL ovf_max4: %0d beats ovf=%0b, required 4 beats second cycle id1 ovf=0",
               got1.size() - b1, d1_ovf);
    end
  endtask

  task automatic test_back_to_back();
    int b, cyc;
    set_triangle();
    for (int r = 0; r < 2; r++) begin
      b = got1.size();
      run_scan(1'b0, cyc);
      tests_run++;
      if (got1.size() - b != 3 || got1[b+2] !== 17) begin
        failures++;
        $display("FAIL b2b_run%0d: %0d beats, required 3 ending with 17", r, got1.size() - b);
      end
    end
    tests_run++;
    if (d2_ovf !== 1'b0) begin
      failures++;
      $display("FAIL b2b_ovf_clear: overflow=%0b, required 0", d2_ovf);
    end
  endtask

  task automatic test_reset_mid_emit();
    int b, n, cyc;
    set_triangle();
    cyc_ready = 1'b0;
    pulse_start();
    n = 0;
    while (!d1_valid && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    tests_run++;
    if (!d1_valid) begin
      failures++;
      $display("FAIL rst_emit_wait: valid=%0b, required 1", d1_valid);
    end
    cycle_reset = 1'b1;
    @(posedge clk); #1;
    tests_run++;
    if ({d1_valid, d1_last, d1_vert, d1_id, d1_busy, d1_done, d1_ovf, d1_terr, d1_aa, d1_ab} !== '0) begin
      failures++;
      $display("FAIL rst_emit_outputs: valid=%0b vert=%0d busy=%0b addr_b=%0d, required all 0",
               d1_valid, d1_vert, d1_busy, d1_ab);
    end
    cycle_reset = 1'b0;
    cyc_ready = 1'b1;
    @(posedge clk); #1;
    b = got1.size();
    run_scan(1'b0, cyc);
    tests_run++;
    if (got1.size() - b != 3 || got1[b] !== 0 || got1[b+2] !== 17) begin
      failures++;
      $display("FAIL rst_emit_rerun: %0d beats, required 3 (0 2 17)", got1.size() - b);
    end
  endtask

  function automatic int rand_w();
    int sel;
    sel = $urandom_range(0, 7);
    if (sel == 0) return 32'h7fffffff;
    if (sel == 1) return 32'h80000000;
    return $urandom_range(0, 16) - 8;
  endfunction

  task automatic test_random();
    int b1, b2, cyc, h0;
    int exp1[$];
    bit ovf1, terr1;
    h0 = hold_err;
    for (int it = 0; it < 40; it++) begin
      for (int x = 0; x < NODES; x++) begin
        vmem[x] = mkv($urandom_range(0, NODES - 1), rand_w());
        for (int y = 0; y < NODES; y++)
          amem[x][y] = ($urandom_range(0, 2) == 0) ? 0 : rand_w();
      end
      model(MAX1);
      exp1 = exp_q;
      ovf1 = exp_ovf;
      terr1 = exp_terr;
      model(MAX2);
      b1 = got1.size();
      b2 = got2.size();
      run_scan(1'b1, cyc);
      tests_run++;
      if (got1.size() - b1 != exp1.size()) begin
        failures++;
        $display("FAIL rnd%0d_len1: %0d beats, required %0d", it, got1.size() - b1, exp1.size());
      end
      for (int k = 0; k < exp1.size() && b1 + k < got1.size(); k++) begin
        tests_run++;
        if (got1[b1+k] !== exp1[k]) begin
          failures++;
          $display("FAIL rnd%0d_beat1_%0d: beat %0d, required %0d", it, k, got1[b1+k], exp1[k]);
        end
      end
      tests_run++;
      if (got2.size() - b2 != exp_q.size()) begin
        failures++;
        $display("FAIL rnd%0d_len2: %0d beats, required %0d", it, got2.size() - b2, exp_q.size());
      end
      for (int k = 0; k < exp_q.size() && b2 + k < got2.size(); k++) begin
        tests_run++;
        if (got2[b2+k] !== exp_q[k]) begin
          failures++;
          $display("FAIL rnd%0d_beat2_%0d: beat %0d, required %0d", it, k, got2[b2+k], exp_q[k]);
        end
      end
      tests_run++;
      if ({d1_ovf, d1_terr, d2_ovf, d2_terr} !== {ovf1, terr1, exp_ovf, exp_terr}) begin
        failures++;
        $display("FAIL rnd%0d_flags: ovf/terr %0b%0b %0b%0b, required %0b%0b %0b%0b", it,
                 d1_ovf, d1_terr, d2_ovf, d2_terr, ovf1, terr1, exp_ovf, exp_terr);
      end
    end
    tests_run++;
    if (hold_err != h0) begin
      failures++;
      $display("FAIL rnd_hold: %0d stalled beats changed, required 0", hold_err - h0);
    end
  endtask

  initial begin
    clear_graph();
    test_reset();
    test_no_cycle();
    test_triangle();
    test_backpressure();
    test_self_loop();
    test_overflow();
    test_back_to_back();
    test_reset_mid_emit();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end

endmodule
